// File: rtl/window_gen_3x3.sv
// Streaming 3x3 sliding-window generator for raster-order pixels.
// Two line buffers supply rows r-2 and r-1; a 3x3 shift register holds the
// live window. A registered copy of the window, its centre coordinates and a
// frame-done flag are presented one cycle after each accept that completes a
// full window.
module window_gen_3x3 #(
  parameter int unsigned ELEMENT_WIDTH = 32,
  parameter int unsigned IMG_WIDTH     = 16,
  parameter int unsigned IMG_HEIGHT    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            t,
  input  logic [ELEMENT_WIDTH-1:0]        pixel_in,
  output logic                            t_out,
  output logic [9*ELEMENT_WIDTH-1:0]      win_data,
  output logic [$clog2(IMG_HEIGHT)-1:0]   center_row,
  output logic [$clog2(IMG_WIDTH)-1:0]    center_col,
  output logic                            frame_done
);

  localparam int unsigned RowW = $clog2(IMG_HEIGHT);
  localparam int unsigned ColW = $clog2(IMG_WIDTH);

  localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);
  localparam logic [RowW-1:0] RowOne  = RowW'(1);
  localparam logic [RowW-1:0] RowMin  = RowW'(2);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
  localparam logic [ColW-1:0] ColOne  = ColW'(1);
  localparam logic [ColW-1:0] ColMin  = ColW'(2);

  typedef logic [ELEMENT_WIDTH-1:0] elem_t;
  // Element (i,j) lives at index 3*i+j, matching the win_data bit layout.
  typedef logic [8:0][ELEMENT_WIDTH-1:0] win_t;

  // Line buffers: lb1 holds row r-1, lb0 holds row r-2. Not reset.
  elem_t lb0_q [IMG_WIDTH];
  elem_t lb1_q [IMG_WIDTH];
  elem_t lb_a, lb_b;

  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;
  win_t            win_q, win_d;

  logic            t_out_q, t_out_d;
  win_t            win_data_q, win_data_d;
  logic [RowW-1:0] center_row_q, center_row_d;
  logic [ColW-1:0] center_col_q, center_col_d;
  logic            frame_done_q, frame_done_d;

  // Next-state: window shift, raster counters and registered output capture.
  always_comb begin
    lb_a         = lb0_q[col_q];
    lb_b         = lb1_q[col_q];
    win_d        = win_q;
    row_d        = row_q;
    col_d        = col_q;
    t_out_d      = 1'b0;
    frame_done_d = 1'b0;
    win_data_d   = win_data_q;
    center_row_d = center_row_q;
    center_col_d = center_col_q;

    if (t) begin
      for (int i = 0; i < 3; i++) begin
        win_d[3*i]     = win_q[3*i + 1];
        win_d[3*i + 1] = win_q[3*i + 2];
      end
      win_d[2] = lb_a;
      win_d[5] = lb_b;
      win_d[8] = pixel_in;

      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + RowOne;
      end else begin
        col_d = col_q + ColOne;
      end

      // c >= 2 masks stale columns from the previous row; r >= 2 masks
      // stale line-buffer contents from the previous frame or reset.
      if (row_q >= RowMin && col_q >= ColMin) begin
        t_out_d      = 1'b1;
        frame_done_d = (row_q == RowLast) && (col_q == ColLast);
        win_data_d   = win_d;
        center_row_d = row_q - RowOne;
        center_col_d = col_q - ColOne;
      end
    end
  end

  // Line-buffer update: read-before-write on the same column address.
  always_ff @(posedge clk) begin
    if (t) begin
      lb0_q[col_q] <= lb_b;
      lb1_q[col_q] <= pixel_in;
    end
  end

  // Counters, window shift register and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q        <= '0;
      col_q        <= '0;
      win_q        <= '0;
      t_out_q      <= 1'b0;
      win_data_q   <= '0;
      center_row_q <= '0;
      center_col_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      row_q        <= row_d;
      col_q        <= col_d;
      win_q        <= win_d;
      t_out_q      <= t_out_d;
      win_data_q   <= win_data_d;
      center_row_q <= center_row_d;
      center_col_q <= center_col_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign t_out      = t_out_q;
  assign win_data   = win_data_q;
  assign center_row = center_row_q;
  assign center_col = center_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3: a 4x4 and a 3x3 instance driven in turn. The
// reference model stores each frame as a 2-D image and cuts expected windows
// out of it; a monitor pops expectations whenever t_out fires.
module tb_window_gen_3x3;

  localparam int EW = 32;

  typedef struct {
    logic [9*EW-1:0] win;
    logic [1:0]      cr;
    logic [1:0]      cc;
    bit              fd;
    int              due;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            t_s   [2];
  logic [EW-1:0]   px_s  [2];
  logic            to_s  [2];
  logic [9*EW-1:0] wd_s  [2];
  logic [1:0]      cr_s  [2];
  logic [1:0]      cc_s  [2];
  logic            fd_s  [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses [2];
  int fdones [2];

  // Reference model state
  logic [EW-1:0]   img [2][4][4];
  int              mr [2];
  int              mc [2];
  exp_t            sb0[$];
  exp_t            sb1[$];
  logic [9*EW-1:0] held_win [2];
  logic [1:0]      held_cr [2];
  logic [1:0]      held_cc [2];

  window_gen_3x3 #(.ELEMENT_WIDTH(EW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut0 (
    .clk(clk), .rst(rst), .t(t_s[0]), .pixel_in(px_s[0]), .t_out(to_s[0]),
    .win_data(wd_s[0]), .center_row(cr_s[0]), .center_col(cc_s[0]), .frame_done(fd_s[0])
  );

  window_gen_3x3 #(.ELEMENT_WIDTH(EW), .IMG_WIDTH(3), .IMG_HEIGHT(3)) dut1 (
    .clk(clk), .rst(rst), .t(t_s[1]), .pixel_in(px_s[1]), .t_out(to_s[1]),
    .win_data(wd_s[1]), .center_row(cr_s[1]), .center_col(cc_s[1]), .frame_done(fd_s[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dim(int id);
    return (id == 0) ? 4 : 3;
  endfunction

  task automatic chk(bit ok, string name, logic [9*EW-1:0] act, logic [9*EW-1:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    sb0.delete();
    sb1.delete();
    for (int id = 0; id < 2; id++) begin
      mr[id] = 0;
      mc[id] = 0;
      held_win[id] = '0;
      held_cr[id] = '0;
      held_cc[id] = '0;
    end
  endtask

  // Record one accepted pixel; if it completes a window, queue the expectation.
  task automatic accept(int id, logic [EW-1:0] px);
    exp_t e;
    int   n;
    n = dim(id);
    img[id][mr[id]][mc[id]] = px;
    if (mr[id] >= 2 && mc[id] >= 2) begin
      e.win = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.win[(3*i+j)*EW +: EW] = img[id][mr[id]-2+i][mc[id]-2+j];
      e.cr  = 2'(mr[id] - 1);
      e.cc  = 2'(mc[id] - 1);
      e.fd  = (mr[id] == n - 1) && (mc[id] == n - 1);
      e.due = cyc + 1;
      if (id == 0) sb0.push_back(e);
      else         sb1.push_back(e);
    end
    mc[id]++;
    if (mc[id] == n) begin
      mc[id] = 0;
      mr[id]++;
      if (mr[id] == n) mr[id] = 0;
    end
  endtask

  task automatic step(int id, bit tv, logic [EW-1:0] px);
    @(negedge clk);
    t_s[0] = 1'b0;
    t_s[1] = 1'b0;
    t_s[id] = tv;
    px_s[id] = px;
    if (tv) accept(id, px);
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 1'b0, '0);
  endtask

  task automatic frame(int id, int base, bit toggle);
    int n;
    n = dim(id);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        step(id, 1'b1, EW'(base + n*r + c));
        if (toggle) step(id, 1'b0, '0);
      end
  endtask

  task automatic rand_frame(int id);
    int n;
    n = dim(id);
    for (int k = 0; k < n*n; k++) begin
      while ($urandom_range(0, 9) >= 7) step(id, 1'b0, EW'($urandom));
      step(id, 1'b1, EW'($urandom));
    end
  endtask

  function automatic int qsize(int id);
    return (id == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic exp_t qpop(int id);
    if (id == 0) return sb0.pop_front();
    return sb1.pop_front();
  endfunction

  function automatic int qdue(int id);
    return (id == 0) ? sb0[0].due : sb1[0].due;
  endfunction

  task automatic mon(int id);
    exp_t e;
    if (to_s[id]) begin
      pulses[id]++;
      if (fd_s[id]) fdones[id]++;
      if (qsize(id) == 0) begin
        chk(1'b0, "unexpected_t_out", 288'(cyc), '0);
      end else begin
        e = qpop(id);
        chk(e.due == cyc, "latency", 288'(cyc), 288'(e.due));
        chk(wd_s[id] == e.win, "win_data", wd_s[id], e.win);
        chk(cr_s[id] == e.cr && cc_s[id] == e.cc, "center",
            288'({cr_s[id], cc_s[id]}), 288'({e.cr, e.cc}));
        chk(fd_s[id] == e.fd, "frame_done", 288'(fd_s[id]), 288'(e.fd));
        held_win[id] = e.win;
        held_cr[id]  = e.cr;
        held_cc[id]  = e.cc;
      end
    end else begin
      if (qsize(id) > 0 && qdue(id) <= cyc) begin
        e = qpop(id);
        chk(1'b0, "missing_t_out", 288'(cyc), 288'(e.due));
      end
      chk(fd_s[id] == 1'b0 && wd_s[id] == held_win[id] && cr_s[id] == held_cr[id] &&
          cc_s[id] == held_cc[id], "hold", wd_s[id], held_win[id]);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    t_s[0] = 1'b0;  t_s[1] = 1'b0;
    px_s[0] = '0;   px_s[1] = '0;
    pulses[0] = 0;  pulses[1] = 0;
    fdones[0] = 0;  fdones[1] = 0;
    model_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    for (int id = 0; id < 2; id++) begin
      chk(to_s[id] == 1'b0 && fd_s[id] == 1'b0, "reset_flags",
          288'({to_s[id], fd_s[id]}), '0);
      chk(wd_s[id] == '0 && cr_s[id] == '0 && cc_s[id] == '0, "reset_data", wd_s[id], '0);
    end
    @(negedge clk);
    rst = 1'b1;

    // Plain frame, t held high
    pulses[0] = 0; fdones[0] = 0;
    frame(0, 0, 1'b0);
    idle(3);
    chk(pulses[0] == 4, "pulse_count_cont", 288'(pulses[0]), 288'(4));
    chk(fdones[0] == 1, "frame_done_count", 288'(fdones[0]), 288'(1));

    // Same frame with t toggling
    pulses[0] = 0;
    frame(0, 0, 1'b1);
    idle(3);
    chk(pulses[0] == 4, "pulse_count_toggle", 288'(pulses[0]), 288'(4));

    // Back-to-back frames
    pulses[0] = 0;
    frame(0, 0, 1'b0);
    frame(0, 100, 1'b0);
    idle(3);
    chk(pulses[0] == 8, "pulse_count_b2b", 288'(pulses[0]), 288'(8));

    // Asynchronous reset while t_out is high, mid-frame
    for (int k = 0; k <= 10; k++) step(0, 1'b1, EW'(k));
    @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk(to_s[0] == 1'b0 && fd_s[0] == 1'b0, "async_reset_flags",
        288'({to_s[0], fd_s[0]}), '0);
    chk(wd_s[0] == '0, "async_reset_win", wd_s[0], '0);
    @(negedge clk);
    t_s[0] = 1'b0;
    rst = 1'b1;
    pulses[0] = 0;
    frame(0, 0, 1'b0);
    idle(3);
    chk(pulses[0] == 4, "pulse_count_after_reset", 288'(pulses[0]), 288'(4));

    // Minimum 3x3 image
    pulses[1] = 0; fdones[1] = 0;
    frame(1, 0, 1'b0);
    idle(3);
    chk(pulses[1] == 1, "pulse_count_3x3", 288'(pulses[1]), 288'(1));
    chk(fdones[1] == 1, "frame_done_3x3", 288'(fdones[1]), 288'(1));

    // Randomized data and gaps
    for (int f = 0; f < 6; f++) begin
      rand_frame(0);
      rand_frame(1);
    end
    idle(4);
    chk(sb0.size() == 0 && sb1.size() == 0, "scoreboard_drained",
        288'(sb0.size() + sb1.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
